wb_pipe_slave: RTL

WB_PIPE_SLAVE -- requirements
Module: wb_pipe_slave

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_req_fifo.sv | 63 ++++++
 rtl/wb_pipe_slave.sv | 129 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the pipelined Wishbone memory slave.
//   wb_state_e : response FSM states (IDLE, WAIT, ACCESS, RESP)
//   wb_req_t   : one queued request {word address, we, sel, dat}
// The word-address field is kept at full bus width (30 bits) so the struct
// does not depend on the memory size; the top uses only its low AWIDTH bits.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = DATA_W / 8;
    localparam int WADR_W = 30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } wb_state_e;

    typedef struct packed {
        logic [WADR_W-1:0] adr;
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_req_fifo.sv
// Request queue for wb_pipe_slave: first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (control state only)
//   flush      : synchronous clear of all entries
//   push, din  : write an entry (ignored when full)
//   pop        : discard the head entry (ignored when empty)
//   dout       : head entry, valid whenever empty is low
//   full/empty : occupancy flags, derived from registered state only
module wb_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_pipe_slave.sv
// Pipelined Wishbone slave in front of a 2**AWIDTH x 32 byte-writable RAM.
// Requests are queued in wb_req_fifo and served one at a time by a
// four-state FSM; each accepted request produces exactly one ack, in order.
//   clk_i   : clock
//   rst_i   : asynchronous active-low reset
//   cyc_i   : bus cycle valid; low on an edge aborts everything outstanding
//   stb_i   : request strobe
//   we_i    : 1 = write, 0 = read
//   adr_i   : byte address, bits [AWIDTH+1:2] select the word
//   sel_i   : byte enables
//   dat_i   : write data
//   dat_o   : read data during ack (0 for writes)
//   ack_o   : one-cycle response pulse
//   stall_o : request queue full
module wb_pipe_slave
    import wb_pkg::*;
#(
    parameter int    AWIDTH     = 12,
    parameter int    FIFO_DEPTH = 4,
    parameter int    WAIT       = 0,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        stall_o
);

    wb_req_t           push_req;
    wb_req_t           head;
    wb_req_t           cur;
    wb_state_e         state;
    logic [3:0]        cnt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              mem_we;
    logic [AWIDTH-1:0] idx;
    logic [31:0]       mem [2**AWIDTH];
    logic              unused_ok;

    assign push_req = '{adr: adr_i[31:2], we: we_i, sel: sel_i, dat: dat_i};
    assign stall_o  = full;
    assign push     = cyc_i && stb_i && !full;
    assign pop      = cyc_i && (state == IDLE) && !empty;

    wb_req_fifo #(
        .WIDTH ($bits(wb_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_i),
        .flush (!cyc_i),
        .push  (push),
        .pop   (pop),
        .din   (push_req),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // The popped request is held here for the WAIT/ACCESS/RESP sequence.
    always_ff @(posedge clk_i) begin
        if (pop) cur <= head;
    end

    assign idx    = cur.adr[AWIDTH-1:0];
    // A dropped cycle cancels the write that would happen on this edge.
    assign mem_we = cyc_i && (state == ACCESS) && cur.we;

    // Address bits outside the word index are intentionally ignored.
    assign unused_ok = &{1'b0, adr_i[1:0], cur.adr[WADR_W-1:AWIDTH]};

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur.sel[b]) mem[idx][8*b +: 8] <= cur.dat[8*b +: 8];
            end
        end
    end

    // ack_o/dat_o are loaded on the ACCESS edge so they are high for
    // exactly the RESP cycle and cleared on every other edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            ack_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= 1'b0;
            dat_o <= '0;
            if (!cyc_i) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!empty) begin
                            cnt   <= 4'(WAIT);
                            state <= (WAIT > 0) ? wb_pkg::WAIT : ACCESS;
                        end
                    end
                    wb_pkg::WAIT: begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) state <= ACCESS;
                    end
                    ACCESS: begin
                        ack_o <= 1'b1;
                        dat_o <= cur.we ? 32'h0 : mem[idx];
                        state <= RESP;
                    end
                    RESP: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
